// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Optional saturating stall counter on the stall_count port: define ID_EX_STALL_COUNT_EN.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              flush,
  input  logic              id_jump,
  input  logic              id_reg_dst,
  input  logic              id_branch_eq,
  input  logic              id_branch_ne,
  input  logic              id_mem_read,
  input  logic              id_mem_to_reg,
  input  logic              id_mem_write,
  input  logic              id_alu_src,
  input  logic              id_reg_write,
  input  logic              id_jr,
  input  logic [3:0]        id_alu_op,
  input  logic [DATA_W-1:0] id_pc_plus4,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [REG_W-1:0]  id_shamt,
  input  logic [5:0]        id_funct,
  output logic              ex_jump,
  output logic              ex_reg_dst,
  output logic              ex_branch_eq,
  output logic              ex_branch_ne,
  output logic              ex_mem_read,
  output logic              ex_mem_to_reg,
  output logic              ex_mem_write,
  output logic              ex_alu_src,
  output logic              ex_reg_write,
  output logic              ex_jr,
  output logic [3:0]        ex_alu_op,
  output logic [DATA_W-1:0] ex_pc_plus4,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic [REG_W-1:0]  ex_shamt,
  output logic [5:0]        ex_funct,
  output logic              ex_valid,
  output logic              stall
`ifdef ID_EX_STALL_COUNT_EN
  , output logic [15:0]     stall_count
`endif
);

  typedef struct packed {
    logic       jump;
    logic       reg_dst;
    logic       branch_eq;
    logic       branch_ne;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       jr;
    logic [3:0] alu_op;
  } ctrl_t;

  ctrl_t id_ctrl;
  ctrl_t ex_ctrl;
  logic  id_uses_rt;
  logic  hazard;
  logic  bubble;

  assign id_ctrl = '{jump: id_jump, reg_dst: id_reg_dst, branch_eq: id_branch_eq,
                     branch_ne: id_branch_ne, mem_read: id_mem_read,
                     mem_to_reg: id_mem_to_reg, mem_write: id_mem_write,
                     alu_src: id_alu_src, reg_write: id_reg_write, jr: id_jr,
                     alu_op: id_alu_op};

  assign ex_jump       = ex_ctrl.jump;
  assign ex_reg_dst    = ex_ctrl.reg_dst;
  assign ex_branch_eq  = ex_ctrl.branch_eq;
  assign ex_branch_ne  = ex_ctrl.branch_ne;
  assign ex_mem_read   = ex_ctrl.mem_read;
  assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
  assign ex_mem_write  = ex_ctrl.mem_write;
  assign ex_alu_src    = ex_ctrl.alu_src;
  assign ex_reg_write  = ex_ctrl.reg_write;
  assign ex_jr         = ex_ctrl.jr;
  assign ex_alu_op     = ex_ctrl.alu_op;

  // rt is a source only for R-type (register operand B) and stores (store data).
  assign id_uses_rt = ~id_alu_src | id_mem_write;
  assign hazard     = ex_valid & ex_ctrl.mem_read & (ex_rt != '0) &
                      ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  // A flush kills the consumer anyway, so stalling behind it would waste a cycle.
  assign stall      = hazard & ~flush & ~hold;
  assign bubble     = flush | stall;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_ctrl     <= '0;
      ex_valid    <= 1'b0;
      ex_pc_plus4 <= '0;
      ex_rd1      <= '0;
      ex_rd2      <= '0;
      ex_imm      <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rd       <= '0;
      ex_shamt    <= '0;
      ex_funct    <= '0;
    end else if (!hold) begin
      // Data fields are captured even for a bubble; only control is squashed.
      ex_pc_plus4 <= id_pc_plus4;
      ex_rd1      <= id_rd1;
      ex_rd2      <= id_rd2;
      ex_imm      <= id_imm;
      ex_rs       <= id_rs;
      ex_rt       <= id_rt;
      ex_rd       <= id_rd;
      ex_shamt    <= id_shamt;
      ex_funct    <= id_funct;
      if (bubble) begin
        ex_ctrl  <= '0;
        ex_valid <= 1'b0;
      end else begin
        ex_ctrl  <= id_ctrl;
        ex_valid <= |id_ctrl;
      end
    end
  end

`ifdef ID_EX_STALL_COUNT_EN
  // stall is already forced low during hold, so the counter holds too.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (stall && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register directly downstream of the decode-stage control unit.
- Captures the decoded control bundle plus operands each cycle and presents them to EX.
- Contains the load-use hazard detector: it drives a stall request back to the PC and IF/ID, and inserts bubbles on stall or on branch/jump flush.

Parameters:
- DATA_W, 32, width of PC, register-file and immediate datapaths
- REG_W, 5, register-specifier width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- hold  in  1  global freeze (memory wait); all state held
- flush  in  1  taken branch/jump resolved in EX; kill the instruction entering EX
- id_jump, id_reg_dst, id_branch_eq, id_branch_ne, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write, id_jr  in  1 each  decode control bits
- id_alu_op  in  4  decode ALU operation
- id_pc_plus4, id_rd1, id_rd2, id_imm  in  DATA_W each  PC+4, register operands, sign-extended immediate
- id_rs, id_rt, id_rd, id_shamt  in  REG_W each  instruction fields
- id_funct  in  6  function field
- ex_* (same names, ex_ prefix)  out  same widths  registered versions of every id_* input
- ex_valid  out  1  EX holds a real instruction (0 = bubble)
- stall  out  1  combinational load-use stall; PC and IF/ID must not update
- stall_count  out  16  present only with the optional feature

Behaviour:
- Reset (reset=0, asynchronous): all ex_* outputs 0, ex_valid=0, stall_count=0. Reset is honoured mid-operation; the next edge after release captures normally.
- Load-use detect (combinational):
  - id_uses_rt = (id_alu_src==0) | id_mem_write.
  - stall = ex_valid & ex_mem_read & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)) & ~flush & ~hold.
- Per-edge update, priority high to low:
  - hold=1: every register keeps its value; stall forced 0.
  - flush=1: capture a bubble. All control outputs become 0, including ex_reg_write, ex_mem_write, ex_mem_read, the branch bits and ex_jump; ex_alu_op=0; ex_valid=0. Data fields are don't-care; the implementation captures them anyway.
  - stall=1: capture a bubble (same as flush). Upstream holds, so the same ID instruction is re-presented next cycle.
  - otherwise: capture all id_* fields; ex_valid = 1 unless every control bit and id_alu_op are 0 (NOP).
- Stall duration: exactly 1 cycle per load-use pair, because the bubble clears ex_mem_read. Back-to-back loads with a dependent consumer each stall once.
- Latency: 1 cycle ID→EX. No combinational path from id_* data to ex_* outputs.
- Register 0: ex_rt==0 never stalls, even when ex_mem_read=1.
- Flush and stall in the same cycle: flush wins and stall deasserts, so upstream may advance past the dead instruction.
- No internal FSM beyond the bubble/valid register. The stall counter, when enabled, is a saturating counter.

Optional Feature:
- Macro ID_EX_STALL_COUNT_EN.
- Defined: stall_count port exists. It is a 16-bit counter that increments on every edge where stall=1, saturates at 16'hFFFF, is cleared by reset, and holds during hold.
- Undefined: the port and counter are absent and all other behaviour is identical.

Test Plan:
- Reset mid-stream: assert reset=0 async between edges with valid data in EX → ex_valid=0, ex_reg_write=0, ex_alu_op=0 immediately; first edge after release captures the ID instruction.
- Load-use: lw $8 in EX (ex_mem_read=1, ex_rt=8), ID add rs=8 → stall=1 for one cycle, EX gets bubble (ex_valid=0); next edge captures the add with ex_valid=1, stall=0.
- rt-use rules: lw $9 in EX, ID addi rt=9 (alu_src=1) → stall=0; ID sw rt=9 (mem_write=1) → stall=1; lw $0 in EX, ID rs=0 → stall=0.
- Flush vs stall: load-use condition true and flush=1 same cycle → stall=0, EX gets bubble, ex_reg_write=0, ex_mem_write=0.
- Hold: hold=1 for 3 cycles with changing id_* inputs and a load-use condition → all ex_* unchanged, stall=0; on release, normal capture/stall resumes.
- With ID_EX_STALL_COUNT_EN: 5 load-use pairs → stall_count=5; preload near 16'hFFFF → stall_count saturates at 16'hFFFF.
